hist2d_acq_ctrl: RTL and testbench
==================================

// Module: hist2d_acq_ctrl
// PURPOSE
//  Acquisition sequencer for hist2d. Latches a run configuration on start, then takes I/Q samples from an
//  upstream valid/ready stream and issues them to hist2d one at a time as single-cycle data_in pulses.
//  After each pulse it waits for hist2d's i_q_found acknowledge. After num_data_pts samples it collects
//  the bin readout (bin_found strobes) and forwards it downstream, then pulses done.
//  Sits between the sampler and hist2d. hist2d is always driven in batch mode (stream_mode=0).
// PARAMETERS
//  TIMEOUT  1024  max cycles waiting for an ack or the next bin_found before aborting with error
//  MIN_GAP  4     min cycles from one h_data_in pulse to the next (hist2d settling)
// PORTS
//  clk100          in   1   system clock; all logic on rising edge
//  rst             in   1   synchronous, active-high reset
//  start           in   1   1-cycle run request; ignored unless state==IDLE
//  abort           in   1   return to IDLE at next edge (no error, no done)
//  cfg_i_bin_num   in   8   I bins for the run
//  cfg_q_bin_num   in   8   Q bins for the run
//  cfg_num_pts     in   16  samples per run
//  s_valid         in   1   upstream sample valid
//  s_ready         out  1   upstream sample accepted when s_valid&s_ready
//  s_i, s_q        in   32  signed sample values
//  h_data_in       out  1   to hist2d.data_in
//  h_i_val,h_q_val out  32  to hist2d.i_val/q_val; held stable from pulse until ack
//  h_num_data_pts  out  16  latched cfg_num_pts
//  h_i_bin_num     out  8   latched cfg_i_bin_num
//  h_q_bin_num     out  8   latched cfg_q_bin_num
//  h_stream_mode   out  1   constant 0
//  h_i_q_found     in   1   hist2d per-sample acknowledge
//  h_bin_found     in   1   hist2d readout strobe
//  h_i_bin_coord   in   8   readout I coordinate
//  h_q_bin_coord   in   8   readout Q coordinate
//  h_bin_val       in   16  readout bin count
//  m_valid         out  1   1-cycle readout strobe (no backpressure)
//  m_i_coord       out  8   registered copy of h_i_bin_coord
//  m_q_coord       out  8   registered copy of h_q_bin_coord
//  m_bin_val       out  16  registered copy of h_bin_val
//  busy            out  1   high when state!=IDLE
//  done            out  1   1-cycle pulse: run complete
//  error           out  1   1-cycle pulse: timeout or bad config
//  sample_cnt      out  16  samples acknowledged this run
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0, including latched cfg, h_* and sample_cnt.
//  IDLE:
//   - start with cfg_num_pts==0, or either bin_num==0 -> error pulse, stay IDLE.
//   - Otherwise latch cfg, sample_cnt=0, go to FEED.
//  FEED:
//   - s_ready=1 only here, and only once the MIN_GAP count has elapsed.
//   - On handshake, register s_i/s_q into h_i_val/h_q_val, assert h_data_in for exactly the next cycle,
//     restart the gap counter, go to WAIT_ACK.
//  WAIT_ACK:
//   - h_i_q_found -> sample_cnt+1; go to READOUT if the new count==num_pts, else FEED.
//   - An ack arriving in the same cycle as h_data_in counts.
//   - No ack within TIMEOUT cycles -> error, IDLE.
//  READOUT:
//   - Each h_bin_found -> m_valid next cycle with registered coord/value. bin_cnt increments.
//   - bin_cnt reaching i_bin_num*q_bin_num (16-bit product; 255*255 fits) -> DONE.
//   - TIMEOUT counter restarts on every h_bin_found; expiry -> error, IDLE.
//   - h_bin_found outside READOUT is ignored. h_i_q_found outside WAIT_ACK is ignored.
//  DONE: done=1 for one cycle, then IDLE.
//  Priority: rst > abort > timeout > normal transitions. Abort mid-run clears h_data_in but not sample_cnt.
//  Latency: s handshake -> h_data_in 1 cycle; h_bin_found -> m_valid 1 cycle.
//  Counters saturate; they never wrap.
// TESTING
//  1. Config 10x10 bins, pts=5; samples -3..1 with s_valid held high; hist2d model acks 3 cycles after
//     each pulse -> 5 h_data_in pulses at least MIN_GAP apart; sample_cnt=5; state enters READOUT.
//  2. Continue test 1: model emits 100 bin_found strobes -> 100 m_valid, each 1 cycle after its strobe,
//     data matching; done pulse on the cycle after the 100th m_valid; busy drops.
//  3. start with cfg_num_pts=0 -> error pulse 1 cycle later; busy stays 0; no h_data_in.
//  4. Model never acks -> error exactly TIMEOUT cycles after h_data_in; IDLE; a fresh start then runs
//     normally.
//  5. abort asserted mid-FEED with 2/5 samples done -> IDLE next cycle, sample_cnt holds 2, no done
//     or error; rst then clears sample_cnt to 0.
//  6. s_valid toggling 1/0 and ack in the same cycle as the pulse -> no sample lost or duplicated;
//     h_i_val stable until ack.

Source files
------------

// File: rtl/hist2d_acq_ctrl_if.sv
// Signal bundle between the acquisition sequencer, the upstream sampler,
// hist2d and the downstream readout consumer.
// Valid/ready rule: the upstream sample (s_i, s_q) is transferred on a
// rising clk100 edge where s_valid and s_ready are both high. The producer
// keeps the data stable while s_valid is high. m_valid is a one-cycle strobe
// with no backpressure.
interface hist2d_acq_ctrl_if;
  // run control and configuration
  logic               start;
  logic               abort;
  logic [7:0]         cfg_i_bin_num;
  logic [7:0]         cfg_q_bin_num;
  logic [15:0]        cfg_num_pts;
  // upstream sample stream
  logic               s_valid;
  logic               s_ready;
  logic signed [31:0] s_i;
  logic signed [31:0] s_q;
  // hist2d side
  logic               h_data_in;
  logic signed [31:0] h_i_val;
  logic signed [31:0] h_q_val;
  logic [15:0]        h_num_data_pts;
  logic [7:0]         h_i_bin_num;
  logic [7:0]         h_q_bin_num;
  logic               h_stream_mode;
  logic               h_i_q_found;
  logic               h_bin_found;
  logic [7:0]         h_i_bin_coord;
  logic [7:0]         h_q_bin_coord;
  logic [15:0]        h_bin_val;
  // downstream readout
  logic               m_valid;
  logic [7:0]         m_i_coord;
  logic [7:0]         m_q_coord;
  logic [15:0]        m_bin_val;
  // status
  logic               busy;
  logic               done;
  logic               error;
  logic [15:0]        sample_cnt;
  logic [2:0]         state_dbg;

  // Sequencer view
  modport master (
    input  start, abort, cfg_i_bin_num, cfg_q_bin_num, cfg_num_pts,
    input  s_valid, s_i, s_q,
    input  h_i_q_found, h_bin_found, h_i_bin_coord, h_q_bin_coord, h_bin_val,
    output s_ready,
    output h_data_in, h_i_val, h_q_val, h_num_data_pts, h_i_bin_num, h_q_bin_num,
    output h_stream_mode,
    output m_valid, m_i_coord, m_q_coord, m_bin_val,
    output busy, done, error, sample_cnt, state_dbg
  );

  // Environment view (sampler, hist2d, consumer, run controller)
  modport slave (
    output start, abort, cfg_i_bin_num, cfg_q_bin_num, cfg_num_pts,
    output s_valid, s_i, s_q,
    output h_i_q_found, h_bin_found, h_i_bin_coord, h_q_bin_coord, h_bin_val,
    input  s_ready,
    input  h_data_in, h_i_val, h_q_val, h_num_data_pts, h_i_bin_num, h_q_bin_num,
    input  h_stream_mode,
    input  m_valid, m_i_coord, m_q_coord, m_bin_val,
    input  busy, done, error, sample_cnt, state_dbg
  );
endinterface

// File: rtl/hist2d_acq_ctrl.sv
// Acquisition sequencer for hist2d: latches a run configuration, feeds
// samples one at a time as single-cycle data_in pulses (waiting for each
// acknowledge and enforcing a minimum pulse spacing), then forwards the bin
// readout and pulses done. Every counter saturates instead of wrapping.
module hist2d_acq_ctrl #(
  parameter int TIMEOUT = 1024,
  parameter int MIN_GAP = 4
) (
  input logic               clk100,
  input logic               rst,
  hist2d_acq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FEED     = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_READOUT  = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);

  state_t             state_q, state_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [15:0]        sample_cnt_q, sample_cnt_d;
  logic [15:0]        bin_cnt_q, bin_cnt_d;
  logic [15:0]        num_pts_q, num_pts_d;
  logic [7:0]         i_bin_q, i_bin_d;
  logic [7:0]         q_bin_q, q_bin_d;
  logic signed [31:0] h_i_val_q, h_i_val_d;
  logic signed [31:0] h_q_val_q, h_q_val_d;
  logic               h_data_in_q, h_data_in_d;
  logic               m_valid_q, m_valid_d;
  logic [7:0]         m_i_coord_q, m_i_coord_d;
  logic [7:0]         m_q_coord_q, m_q_coord_d;
  logic [15:0]        m_bin_val_q, m_bin_val_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic        cfg_bad, s_ready, hs, ack_fire, bin_fire;
  logic        last_sample, last_bin, tmo_expire;
  logic [15:0] cnt_inc, bin_inc, bins_total;

  // Run qualifiers shared by the next-state and datapath logic
  assign cfg_bad     = (bus.cfg_num_pts == 16'd0) || (bus.cfg_i_bin_num == 8'd0) ||
                       (bus.cfg_q_bin_num == 8'd0);
  assign s_ready     = (state_q == ST_FEED) && (gap_q >= GW'(MIN_GAP)) && !bus.abort;
  assign hs          = s_ready && bus.s_valid;
  assign ack_fire    = (state_q == ST_WAIT_ACK) && bus.h_i_q_found;
  assign bin_fire    = (state_q == ST_READOUT) && bus.h_bin_found;
  assign cnt_inc     = (sample_cnt_q == 16'hFFFF) ? sample_cnt_q : sample_cnt_q + 16'd1;
  assign bin_inc     = (bin_cnt_q == 16'hFFFF) ? bin_cnt_q : bin_cnt_q + 16'd1;
  assign bins_total  = 16'(i_bin_q) * 16'(q_bin_q);
  assign last_sample = ack_fire && (cnt_inc == num_pts_q);
  assign last_bin    = bin_fire && (bin_inc == bins_total);
  // Expiry only when the awaited event is absent in the final allowed cycle
  assign tmo_expire  = (tmo_q == TW'(TIMEOUT - 1)) &&
                       (((state_q == ST_WAIT_ACK) && !bus.h_i_q_found) ||
                        ((state_q == ST_READOUT) && !bus.h_bin_found));

  // State register
  always_ff @(posedge clk100) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: abort beats timeout beats normal transitions
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else if (tmo_expire) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     if (bus.start && !cfg_bad) state_d = ST_FEED;
        ST_FEED:     if (hs) state_d = ST_WAIT_ACK;
        ST_WAIT_ACK: if (ack_fire) state_d = last_sample ? ST_READOUT : ST_FEED;
        ST_READOUT:  if (last_bin) state_d = ST_DONE;
        ST_DONE:     state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Output/datapath logic: pulses default low, everything else holds
  always_comb begin
    tmo_d        = (tmo_q == {TW{1'b1}}) ? tmo_q : tmo_q + 1'b1;
    gap_d        = (gap_q == {GW{1'b1}}) ? gap_q : gap_q + 1'b1;
    sample_cnt_d = sample_cnt_q;
    bin_cnt_d    = bin_cnt_q;
    num_pts_d    = num_pts_q;
    i_bin_d      = i_bin_q;
    q_bin_d      = q_bin_q;
    h_i_val_d    = h_i_val_q;
    h_q_val_d    = h_q_val_q;
    h_data_in_d  = 1'b0;
    m_valid_d    = 1'b0;
    m_i_coord_d  = m_i_coord_q;
    m_q_coord_d  = m_q_coord_q;
    m_bin_val_d  = m_bin_val_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    if (bus.abort) begin
      // back to idle quietly; sample_cnt keeps its value
    end else if (tmo_expire) begin
      error_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (cfg_bad) begin
              error_d = 1'b1;
            end else begin
              num_pts_d    = bus.cfg_num_pts;
              i_bin_d      = bus.cfg_i_bin_num;
              q_bin_d      = bus.cfg_q_bin_num;
              sample_cnt_d = 16'd0;
              bin_cnt_d    = 16'd0;
              tmo_d        = '0;
              gap_d        = GW'(MIN_GAP);  // first sample may go at once
            end
          end
        end
        ST_FEED: begin
          if (hs) begin
            h_i_val_d   = bus.s_i;
            h_q_val_d   = bus.s_q;
            h_data_in_d = 1'b1;
            gap_d       = GW'(1);  // the pulse cycle is the first gap cycle
            tmo_d       = '0;
          end
        end
        ST_WAIT_ACK: begin
          if (ack_fire) begin
            sample_cnt_d = cnt_inc;
            bin_cnt_d    = 16'd0;
            tmo_d        = '0;
          end
        end
        ST_READOUT: begin
          if (bin_fire) begin
            m_valid_d   = 1'b1;
            m_i_coord_d = bus.h_i_bin_coord;
            m_q_coord_d = bus.h_q_bin_coord;
            m_bin_val_d = bus.h_bin_val;
            bin_cnt_d   = bin_inc;
            tmo_d       = '0;
          end
        end
        ST_DONE: done_d = 1'b1;
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk100) begin
    if (rst) begin
      tmo_q        <= '0;
      gap_q        <= '0;
      sample_cnt_q <= '0;
      bin_cnt_q    <= '0;
      num_pts_q    <= '0;
      i_bin_q      <= '0;
      q_bin_q      <= '0;
      h_i_val_q    <= '0;
      h_q_val_q    <= '0;
      h_data_in_q  <= 1'b0;
      m_valid_q    <= 1'b0;
      m_i_coord_q  <= '0;
      m_q_coord_q  <= '0;
      m_bin_val_q  <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
      sample_cnt_q <= sample_cnt_d;
      bin_cnt_q    <= bin_cnt_d;
      num_pts_q    <= num_pts_d;
      i_bin_q      <= i_bin_d;
      q_bin_q      <= q_bin_d;
      h_i_val_q    <= h_i_val_d;
      h_q_val_q    <= h_q_val_d;
      h_data_in_q  <= h_data_in_d;
      m_valid_q    <= m_valid_d;
      m_i_coord_q  <= m_i_coord_d;
      m_q_coord_q  <= m_q_coord_d;
      m_bin_val_q  <= m_bin_val_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.s_ready        = s_ready;
  assign bus.h_data_in      = h_data_in_q;
  assign bus.h_i_val        = h_i_val_q;
  assign bus.h_q_val        = h_q_val_q;
  assign bus.h_num_data_pts = num_pts_q;
  assign bus.h_i_bin_num    = i_bin_q;
  assign bus.h_q_bin_num    = q_bin_q;
  assign bus.h_stream_mode  = 1'b0;
  assign bus.m_valid        = m_valid_q;
  assign bus.m_i_coord      = m_i_coord_q;
  assign bus.m_q_coord      = m_q_coord_q;
  assign bus.m_bin_val      = m_bin_val_q;
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.done           = done_q;
  assign bus.error          = error_q;
  assign bus.sample_cnt     = sample_cnt_q;
  assign bus.state_dbg      = state_q;

endmodule

// File: tb/tb_hist2d_acq_ctrl.sv
// Bench for hist2d_acq_ctrl: a behavioural sampler/hist2d/consumer model
// driven cycle by cycle, with expected sample and readout queues.
module tb_hist2d_acq_ctrl;
  localparam int TIMEOUT = 1024;
  localparam int MIN_GAP = 4;

  logic clk100 = 1'b0;
  logic rst    = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic [63:0] exp_q[$];  // {i, q} samples accepted, awaiting their pulse
  logic [31:0] rd_q[$];   // {i_coord, q_coord, bin_val} strobed, awaiting m_valid
  logic [15:0] m_pts;
  logic [7:0]  m_ni, m_nq;

  hist2d_acq_ctrl_if bus ();

  hist2d_acq_ctrl #(.TIMEOUT(TIMEOUT), .MIN_GAP(MIN_GAP)) dut (
    .clk100 (clk100),
    .rst    (rst),
    .bus    (bus)
  );

  // clock / watchdog
  always #5 clk100 = ~clk100;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk100);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.abort = 0;
    bus.cfg_i_bin_num = 0; bus.cfg_q_bin_num = 0; bus.cfg_num_pts = 0;
    bus.s_valid = 0; bus.s_i = 0; bus.s_q = 0;
    bus.h_i_q_found = 0; bus.h_bin_found = 0;
    bus.h_i_bin_coord = 0; bus.h_q_bin_coord = 0; bus.h_bin_val = 0;
  endtask

  task automatic start_run(input int ni, input int nq, input int pts);
    exp_q.delete();
    rd_q.delete();
    m_ni = 8'(ni); m_nq = 8'(nq); m_pts = 16'(pts);
    bus.cfg_i_bin_num = m_ni; bus.cfg_q_bin_num = m_nq; bus.cfg_num_pts = m_pts;
    bus.start = 1;
    tick();
    bus.start = 0;
    checks++;
    if ({bus.busy, bus.sample_cnt} !== {1'b1, 16'd0})
      begin errors++; $display("FAIL start_busy got busy=%0b cnt=%0d exp busy=1 cnt=0", bus.busy, bus.sample_cnt); end
  endtask

  // Sampler + hist2d model up to stop_acks acknowledged samples.
  task automatic feed_phase(input int stop_acks, input int ack_dly, input bit toggle,
                            input bit noise, input bit ramp);
    int sent = 0, acks = 0, ack_at = 0, last_pulse = 0, budget = 3000;
    bit waiting = 0, first = 1, hs = 0, ack_now = 0, ack_prev = 0;
    logic [31:0] cur_i, cur_q;
    logic [63:0] held, exp_v;
    cur_i = ramp ? 32'(sent - 3) : $urandom;
    cur_q = ramp ? 32'(sent - 3) : $urandom;
    while (acks < stop_acks && budget > 0) begin
      budget--;
      checks++;
      if (bus.h_data_in !== hs)
        begin errors++; $display("FAIL pulse_latency cyc=%0d got %0b exp %0b", cyc, bus.h_data_in, hs); end
      if (bus.h_data_in === 1'b1) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        checks++;
        if ({bus.h_i_val, bus.h_q_val} !== exp_v)
          begin errors++; $display("FAIL pulse_data got %h exp %h", {bus.h_i_val, bus.h_q_val}, exp_v); end
        if (!first) begin
          checks++;
          if (cyc - last_pulse < MIN_GAP)
            begin errors++; $display("FAIL min_gap got %0d exp >=%0d", cyc - last_pulse, MIN_GAP); end
        end
        first = 0; last_pulse = cyc; waiting = 1; ack_at = cyc + ack_dly; held = exp_v;
      end else if (waiting) begin
        checks++;
        if ({bus.h_i_val, bus.h_q_val} !== held)
          begin errors++; $display("FAIL hold_val got %h exp %h", {bus.h_i_val, bus.h_q_val}, held); end
      end
      checks++;
      if ({bus.h_num_data_pts, bus.h_i_bin_num, bus.h_q_bin_num, bus.h_stream_mode} !== {m_pts, m_ni, m_nq, 1'b0})
        begin errors++; $display("FAIL cfg_latched got %h/%h/%h/%b exp %h/%h/%h/0", bus.h_num_data_pts,
          bus.h_i_bin_num, bus.h_q_bin_num, bus.h_stream_mode, m_pts, m_ni, m_nq); end
      if (ack_prev) begin
        checks++;
        if (bus.sample_cnt !== 16'(acks))
          begin errors++; $display("FAIL sample_cnt got %0d exp %0d", bus.sample_cnt, acks); end
      end
      checks++;
      if ({bus.m_valid, bus.done, bus.error} !== 3'b000)
        begin errors++; $display("FAIL feed_stray got m_valid/done/error=%b exp 000", {bus.m_valid, bus.done, bus.error}); end
      // drive the next cycle
      ack_now = waiting && (cyc == ack_at);
      bus.h_i_q_found = ack_now;
      bus.h_bin_found = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.h_i_bin_coord = 8'($urandom); bus.h_q_bin_coord = 8'($urandom); bus.h_bin_val = 16'($urandom);
      bus.cfg_num_pts = 16'($urandom); bus.cfg_i_bin_num = 8'($urandom); bus.cfg_q_bin_num = 8'($urandom);
      bus.s_valid = (sent < int'(m_pts)) && (toggle ? (cyc % 2 == 0) : 1'b1);
      bus.s_i = cur_i; bus.s_q = cur_q;
      #1;
      if (waiting) begin
        checks++;
        if (bus.s_ready !== 1'b0)
          begin errors++; $display("FAIL ready_while_waiting got %0b exp 0", bus.s_ready); end
      end
      hs = bus.s_valid && bus.s_ready;
      if (hs) begin
        exp_q.push_back({cur_i, cur_q});
        sent++;
        cur_i = ramp ? 32'(sent - 3) : $urandom;
        cur_q = ramp ? 32'(sent - 3) : $urandom;
      end
      if (ack_now) begin waiting = 0; acks++; end
      ack_prev = ack_now;
      tick();
    end
    bus.h_i_q_found = 0; bus.h_bin_found = 0; bus.s_valid = 0;
    checks++;
    if (budget == 0 || bus.sample_cnt !== 16'(acks) || acks != stop_acks)
      begin errors++; $display("FAIL feed_end got cnt=%0d acks=%0d exp %0d", bus.sample_cnt, acks, stop_acks); end
  endtask

  // hist2d readout model: i_bin*q_bin strobes with random spacing.
  task automatic readout_phase();
    int total, sent = 0, got = 0, budget;
    bit strobe = 0, strobe_prev = 0;
    logic [31:0] exp_v;
    total = int'(m_ni) * int'(m_nq);
    budget = total * 6 + 50;
    while (got < total && budget > 0) begin
      budget--;
      checks++;
      if (bus.m_valid !== strobe_prev)
        begin errors++; $display("FAIL mvalid_latency cyc=%0d got %0b exp %0b", cyc, bus.m_valid, strobe_prev); end
      if (bus.m_valid === 1'b1) begin
        exp_v = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hx;
        checks++;
        if ({bus.m_i_coord, bus.m_q_coord, bus.m_bin_val} !== exp_v)
          begin errors++; $display("FAIL readout_data got %h exp %h", {bus.m_i_coord, bus.m_q_coord, bus.m_bin_val}, exp_v); end
        got++;
      end
      checks++;
      if ({bus.done, bus.error, bus.h_data_in} !== 3'b000)
        begin errors++; $display("FAIL readout_stray got done/error/data_in=%b exp 000", {bus.done, bus.error, bus.h_data_in}); end
      strobe = (sent < total) && ($urandom_range(0, 3) != 0);
      bus.h_bin_found = strobe;
      bus.h_i_bin_coord = 8'($urandom); bus.h_q_bin_coord = 8'($urandom); bus.h_bin_val = 16'($urandom);
      bus.h_i_q_found = 1'($urandom_range(0, 1));
      if (strobe) begin
        rd_q.push_back({bus.h_i_bin_coord, bus.h_q_bin_coord, bus.h_bin_val});
        sent++;
      end
      strobe_prev = strobe;
      tick();
    end
    bus.h_bin_found = 0; bus.h_i_q_found = 0;
    checks++;
    if (budget == 0 || {bus.done, bus.busy, bus.error, bus.m_valid} !== 4'b1000)
      begin errors++; $display("FAIL done_pulse got done/busy/error/m_valid=%b exp 1000 (got %0d of %0d)",
        {bus.done, bus.busy, bus.error, bus.m_valid}, got, total); end
    tick();
    checks++;
    if (bus.done !== 1'b0)
      begin errors++; $display("FAIL done_width got %0b exp 0", bus.done); end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (3) tick();
    checks++;
    if ({bus.busy, bus.done, bus.error, bus.s_ready, bus.h_data_in, bus.m_valid, bus.h_stream_mode,
         bus.sample_cnt, bus.h_num_data_pts, bus.h_i_bin_num, bus.h_q_bin_num, bus.h_i_val, bus.h_q_val,
         bus.m_i_coord, bus.m_q_coord, bus.m_bin_val} !== '0)
      begin errors++; $display("FAIL reset_outputs got nonzero, exp all zero (busy=%0b cnt=%0d)", bus.busy, bus.sample_cnt); end
    rst = 0;
    tick();
  endtask

  task automatic test_basic_run();
    start_run(10, 10, 5);
    feed_phase(5, 3, 0, 1, 1);
    checks++;
    if ({bus.busy, bus.s_ready, bus.sample_cnt} !== {1'b1, 1'b0, 16'd5})
      begin errors++; $display("FAIL enter_readout got busy=%0b ready=%0b cnt=%0d exp 1 0 5", bus.busy, bus.s_ready, bus.sample_cnt); end
    readout_phase();
  endtask

  task automatic test_bad_cfg();
    for (int v = 0; v < 3; v++) begin
      bus.cfg_num_pts   = (v == 0) ? 16'd0 : 16'd5;
      bus.cfg_i_bin_num = (v == 1) ? 8'd0 : 8'd10;
      bus.cfg_q_bin_num = (v == 2) ? 8'd0 : 8'd10;
      bus.s_valid = 1;
      bus.start = 1;
      tick();
      bus.start = 0;
      checks++;
      if ({bus.error, bus.busy} !== 2'b10)
        begin errors++; $display("FAIL bad_cfg_error v=%0d got error/busy=%b exp 10", v, {bus.error, bus.busy}); end
      for (int k = 0; k < 4; k++) begin
        tick();
        checks++;
        if ({bus.error, bus.busy, bus.h_data_in, bus.s_ready} !== 4'b0000)
          begin errors++; $display("FAIL bad_cfg_idle v=%0d got %b exp 0000", v, {bus.error, bus.busy, bus.h_data_in, bus.s_ready}); end
      end
      bus.s_valid = 0;
    end
  endtask

  task automatic test_ack_timeout();
    bit found = 0;
    int err_at = -1;
    start_run(2, 2, 3);
    bus.s_valid = 1; bus.s_i = $urandom; bus.s_q = $urandom;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (bus.h_data_in === 1'b1) begin found = 1; bus.s_valid = 0; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL ack_tmo_pulse got no h_data_in exp one within 20 cycles"); end
    for (int j = 1; j <= TIMEOUT + 3; j++) begin
      tick();
      if (bus.error === 1'b1 && err_at < 0) err_at = j;
    end
    checks++;
    if (err_at != TIMEOUT)
      begin errors++; $display("FAIL ack_tmo_time got %0d exp %0d", err_at, TIMEOUT); end
    checks++;
    if ({bus.busy, bus.error, bus.done} !== 3'b000)
      begin errors++; $display("FAIL ack_tmo_idle got busy/error/done=%b exp 000", {bus.busy, bus.error, bus.done}); end
    start_run(2, 2, 3);
    feed_phase(3, $urandom_range(0, 5), 0, 0, 0);
    readout_phase();
  endtask

  task automatic test_readout_timeout();
    int err_at = -1;
    start_run(3, 2, 2);
    feed_phase(2, 1, 0, 0, 0);
    bus.h_bin_found = 1; bus.h_i_bin_coord = 8'd7; bus.h_q_bin_coord = 8'd9; bus.h_bin_val = 16'h1234;
    tick();
    bus.h_bin_found = 0;
    checks++;
    if ({bus.m_valid, bus.m_i_coord, bus.m_q_coord, bus.m_bin_val} !== {1'b1, 8'd7, 8'd9, 16'h1234})
      begin errors++; $display("FAIL rd_tmo_strobe got %b %h %h %h exp 1 07 09 1234", bus.m_valid, bus.m_i_coord, bus.m_q_coord, bus.m_bin_val); end
    for (int j = 2; j <= TIMEOUT + 4; j++) begin
      tick();
      if (bus.error === 1'b1 && err_at < 0) err_at = j;
    end
    checks++;
    if (err_at < TIMEOUT || err_at > TIMEOUT + 1)
      begin errors++; $display("FAIL rd_tmo_time got %0d exp %0d..%0d", err_at, TIMEOUT, TIMEOUT + 1); end
    checks++;
    if ({bus.busy, bus.done} !== 2'b00)
      begin errors++; $display("FAIL rd_tmo_idle got busy/done=%b exp 00", {bus.busy, bus.done}); end
  endtask

  task automatic test_abort();
    start_run(10, 10, 5);
    feed_phase(2, 3, 0, 0, 0);
    bus.abort = 1; bus.s_valid = 1; bus.s_i = $urandom; bus.s_q = $urandom;
    tick();
    bus.abort = 0; bus.s_valid = 0;
    checks++;
    if ({bus.busy, bus.done, bus.error, bus.h_data_in, bus.sample_cnt} !== {4'b0000, 16'd2})
      begin errors++; $display("FAIL abort_idle got busy/done/error/data_in=%b cnt=%0d exp 0000 2",
        {bus.busy, bus.done, bus.error, bus.h_data_in}, bus.sample_cnt); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({bus.busy, bus.done, bus.error, bus.h_data_in, bus.sample_cnt} !== {4'b0000, 16'd2})
        begin errors++; $display("FAIL abort_quiet got %b cnt=%0d exp 0000 2",
          {bus.busy, bus.done, bus.error, bus.h_data_in}, bus.sample_cnt); end
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if ({bus.sample_cnt, bus.h_num_data_pts} !== 32'd0)
      begin errors++; $display("FAIL abort_rst_clear got cnt=%0d pts=%0d exp 0 0", bus.sample_cnt, bus.h_num_data_pts); end
  endtask

  task automatic test_toggle_same_cycle_ack();
    start_run(4, 3, 8);
    feed_phase(8, 0, 1, 0, 0);
    readout_phase();
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) begin
      start_run($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6));
      feed_phase(int'(m_pts), $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      readout_phase();
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_bad_cfg();
    test_ack_timeout();
    test_readout_timeout();
    test_abort();
    test_toggle_same_cycle_ack();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
